// File: rtl/mem_responder_if.sv
// Request/response bus between an initiator and the mem_responder.
// The initiator drives the request fields and samples the response strobe.
interface mem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid,
        output req_we,
        output req_addr,
        output req_wdata,
        input  req_ready,
        input  rsp_valid,
        input  rsp_rdata,
        input  rsp_err
    );

    modport slave (
        input  req_valid,
        input  req_we,
        input  req_addr,
        input  req_wdata,
        output req_ready,
        output rsp_valid,
        output rsp_rdata,
        output rsp_err
    );
endinterface

// File: rtl/mem_responder.sv
// Single-outstanding word memory responder with programmable wait states.
// The FSM walks IDLE -> WAIT (WAIT_CYCLES cycles) -> RESP -> IDLE. Memory is
// written on the edge entering RESP, and the response strobe/data are
// registered out of RESP, so they appear WAIT_CYCLES+1 edges after accept.
module mem_responder #(
    parameter int DEPTH_LOG2  = 8,
    parameter int WAIT_CYCLES = 2
) (
    input  logic          clk,
    input  logic          reset,
    mem_responder_if.slave bus
);
    localparam int         DEPTH     = 1 << DEPTH_LOG2;
    localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Misaligned addresses and addresses beyond the array are rejected.
    function automatic logic addr_error(input logic [31:0] addr);
        logic [31:0] upper;
        upper      = addr >> (DEPTH_LOG2 + 2);
        addr_error = (addr[1:0] != 2'b00) || (upper != 32'd0);
    endfunction

    state_t                  state_r;
    state_t                  state_next_s;
    logic [3:0]              cnt_r;
    logic [3:0]              cnt_next_s;
    logic                    accept_s;

    logic                    we_r;
    logic [31:0]             addr_r;
    logic [31:0]             wdata_r;

    logic                    cur_we_s;
    logic [31:0]             cur_addr_s;
    logic [31:0]             cur_wdata_s;
    logic                    mem_we_s;
    logic [DEPTH_LOG2-1:0]   mem_widx_s;
    logic [31:0]             rsp_rdata_next_s;

    logic [31:0]             mem_r [DEPTH];

    logic                    req_ready_r;
    logic                    rsp_valid_r;
    logic [31:0]             rsp_rdata_r;
    logic                    rsp_err_r;

    // Next-state and wait-counter logic; a request is taken only in IDLE.
    always_comb begin
        state_next_s = state_r;
        cnt_next_s   = cnt_r;
        accept_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    accept_s = 1'b1;
                    if (WAIT_CYCLES > 0) begin
                        state_next_s = ST_WAIT;
                        cnt_next_s   = WAIT_LOAD;
                    end else begin
                        state_next_s = ST_RESP;
                        cnt_next_s   = 4'd0;
                    end
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (cnt_r == 4'd0) begin
                    state_next_s = ST_RESP;
                end else begin
                    cnt_next_s = cnt_r - 4'd1;
                end
            end
            ST_RESP: begin
                state_next_s = ST_IDLE;
            end
            default: begin
                state_next_s = ST_IDLE;
                cnt_next_s   = 4'd0;
            end
        endcase
    end

    // With zero wait states RESP is entered on the accept edge itself, so the
    // write must use the live bus fields rather than the latched copy.
    always_comb begin
        if (accept_s) begin
            cur_we_s    = bus.req_we;
            cur_addr_s  = bus.req_addr;
            cur_wdata_s = bus.req_wdata;
        end else begin
            cur_we_s    = we_r;
            cur_addr_s  = addr_r;
            cur_wdata_s = wdata_r;
        end
        mem_widx_s = cur_addr_s[DEPTH_LOG2+1:2];
        mem_we_s   = (state_next_s == ST_RESP) && cur_we_s && !addr_error(cur_addr_s);
    end

    // Response data for the cycle after RESP: read word or zero.
    always_comb begin
        rsp_rdata_next_s = 32'd0;
        if ((state_r == ST_RESP) && !we_r && !addr_error(addr_r)) begin
            rsp_rdata_next_s = mem_r[addr_r[DEPTH_LOG2+1:2]];
        end else begin
            rsp_rdata_next_s = 32'd0;
        end
    end

    // FSM state and wait counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
            cnt_r   <= 4'd0;
        end else begin
            state_r <= state_next_s;
            cnt_r   <= cnt_next_s;
        end
    end

    // Latch the request fields on accept so later bus changes are ignored.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            we_r    <= 1'b0;
            addr_r  <= 32'd0;
            wdata_r <= 32'd0;
        end else if (accept_s) begin
            we_r    <= bus.req_we;
            addr_r  <= bus.req_addr;
            wdata_r <= bus.req_wdata;
        end
    end

    // Storage array: not reset, and never written while reset is held.
    always_ff @(posedge clk) begin
        if (mem_we_s && !reset) begin
            mem_r[mem_widx_s] <= cur_wdata_s;
        end
    end

    // Registered handshake and response outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            req_ready_r <= 1'b1;
            rsp_valid_r <= 1'b0;
            rsp_rdata_r <= 32'd0;
            rsp_err_r   <= 1'b0;
        end else begin
            req_ready_r <= (state_next_s == ST_IDLE);
            rsp_valid_r <= (state_r == ST_RESP);
            rsp_rdata_r <= rsp_rdata_next_s;
            rsp_err_r   <= (state_r == ST_RESP) && addr_error(addr_r);
        end
    end

    assign bus.req_ready = req_ready_r;
    assign bus.rsp_valid = rsp_valid_r;
    assign bus.rsp_rdata = rsp_rdata_r;
    assign bus.rsp_err   = rsp_err_r;
endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: one instance with two wait states and one
// with none, sharing a driver selected by sel.
module tb_mem_responder;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mem_responder_if bus_a ();
    mem_responder_if bus_b ();

    mem_responder #(.DEPTH_LOG2(8), .WAIT_CYCLES(2)) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_a)
    );

    mem_responder #(.DEPTH_LOG2(8), .WAIT_CYCLES(0)) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_b)
    );

    logic        sel;
    logic        drv_valid;
    logic        drv_we;
    logic [31:0] drv_addr;
    logic [31:0] drv_wdata;

    assign bus_a.req_valid = drv_valid & ~sel;
    assign bus_a.req_we    = drv_we;
    assign bus_a.req_addr  = drv_addr;
    assign bus_a.req_wdata = drv_wdata;
    assign bus_b.req_valid = drv_valid & sel;
    assign bus_b.req_we    = drv_we;
    assign bus_b.req_addr  = drv_addr;
    assign bus_b.req_wdata = drv_wdata;

    logic        obs_ready;
    logic        obs_rsp_valid;
    logic [31:0] obs_rdata;
    logic        obs_err;
    assign obs_ready     = sel ? bus_b.req_ready : bus_a.req_ready;
    assign obs_rsp_valid = sel ? bus_b.rsp_valid : bus_a.rsp_valid;
    assign obs_rdata     = sel ? bus_b.rsp_rdata : bus_a.rsp_rdata;
    assign obs_err       = sel ? bus_b.rsp_err   : bus_a.rsp_err;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Call at a falling edge; returns at the falling edge where rsp_valid is seen.
    // lat counts rising edges after the accept edge.
    task automatic txn(input string tag, input logic s, input logic we,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       output int lat, output logic [31:0] rdata,
                       output logic err, output int ready_hi);
        sel       = s;
        drv_valid = 1'b1;
        drv_we    = we;
        drv_addr  = addr;
        drv_wdata = wdata;
        #1;
        check({tag, "_ready_at_accept"}, {31'd0, obs_ready}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        drv_valid = 1'b0;
        drv_we    = ~we;
        drv_addr  = 32'hFFFF_FFF3;
        drv_wdata = 32'hBAD0_BAD0;
        lat       = 0;
        ready_hi  = 0;
        while (!obs_rsp_valid && lat < 20) begin
            if (obs_ready) ready_hi++;
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
        rdata = obs_rdata;
        err   = obs_err;
    endtask

    int          lat;
    int          rdy;
    logic [31:0] rd;
    logic        er;
    int          accepts;
    int          nrsp;
    int          seen;
    logic [31:0] hold_addr [12];
    logic [31:0] hold_rd   [3];
    logic        hold_er   [3];

    initial begin
        reset     = 1'b1;
        sel       = 1'b0;
        drv_valid = 1'b0;
        drv_we    = 1'b0;
        drv_addr  = 32'd0;
        drv_wdata = 32'd0;
        repeat (2) @(negedge clk);

        // Reset state
        check("rst_ready",     {31'd0, obs_ready},     32'd1);
        check("rst_rsp_valid", {31'd0, obs_rsp_valid}, 32'd0);
        check("rst_rdata",     obs_rdata,              32'd0);
        check("rst_err",       {31'd0, obs_err},       32'd0);
        reset = 1'b0;

        // Write 0xDEADBEEF to 0x10, accepted on the first edge after reset
        txn("wr10", 1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF, lat, rd, er, rdy);
        check("wr10_lat",      lat,                32'd3);
        check("wr10_err",      {31'd0, er},        32'd0);
        check("wr10_rdata",    rd,                 32'd0);
        check("wr10_ready_lo", rdy,                32'd0);
        @(posedge clk);
        @(negedge clk);
        check("wr10_pulse",    {31'd0, obs_rsp_valid}, 32'd0);

        // Read it back
        txn("rd10", 1'b0, 1'b0, 32'h10, 32'd0, lat, rd, er, rdy);
        check("rd10_lat",   lat,         32'd3);
        check("rd10_rdata", rd,          32'hDEAD_BEEF);
        check("rd10_err",   {31'd0, er}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        check("idle_rdata_zero", obs_rdata, 32'd0);

        // Known content at word 0 and at the last word
        txn("wr0", 1'b0, 1'b1, 32'h0, 32'h1111_1111, lat, rd, er, rdy);
        check("wr0_err", {31'd0, er}, 32'd0);
        txn("wr3fc", 1'b0, 1'b1, 32'h3FC, 32'hA5A5_A5A5, lat, rd, er, rdy);
        check("wr3fc_err", {31'd0, er}, 32'd0);

        // Error cases: misaligned read, out-of-range write aliasing word 0
        txn("rd11", 1'b0, 1'b0, 32'h11, 32'd0, lat, rd, er, rdy);
        check("rd11_err",   {31'd0, er}, 32'd1);
        check("rd11_rdata", rd,          32'd0);
        check("rd11_lat",   lat,         32'd3);
        txn("wr400", 1'b0, 1'b1, 32'h400, 32'h9999_9999, lat, rd, er, rdy);
        check("wr400_err",   {31'd0, er}, 32'd1);
        check("wr400_rdata", rd,          32'd0);
        txn("rd0", 1'b0, 1'b0, 32'h0, 32'd0, lat, rd, er, rdy);
        check("rd0_rdata", rd,          32'h1111_1111);
        check("rd0_err",   {31'd0, er}, 32'd0);
        txn("rd3fc", 1'b0, 1'b0, 32'h3FC, 32'd0, lat, rd, er, rdy);
        check("rd3fc_rdata", rd, 32'hA5A5_A5A5);

        // Continuous req_valid: only addresses at idle edges 0, 4, 8 are taken
        hold_addr = '{32'h10, 32'h11, 32'h11, 32'h11,
                      32'h0,  32'h11, 32'h11, 32'h11,
                      32'h3FC, 32'h11, 32'h11, 32'h11};
        sel     = 1'b0;
        accepts = 0;
        nrsp    = 0;
        for (int k = 0; k < 12; k++) begin
            drv_valid = 1'b1;
            drv_we    = 1'b0;
            drv_addr  = hold_addr[k];
            #1;
            if (obs_ready) accepts++;
            @(posedge clk);
            @(negedge clk);
            if (obs_rsp_valid) begin
                if (nrsp < 3) begin
                    hold_rd[nrsp] = obs_rdata;
                    hold_er[nrsp] = obs_err;
                end
                nrsp++;
            end
        end
        drv_valid = 1'b0;
        check("hold_accepts", accepts, 32'd3);
        check("hold_rsps",    nrsp,    32'd3);
        check("hold_rd0", hold_rd[0], 32'hDEAD_BEEF);
        check("hold_rd1", hold_rd[1], 32'h1111_1111);
        check("hold_rd2", hold_rd[2], 32'hA5A5_A5A5);
        check("hold_err", {29'd0, hold_er[0], hold_er[1], hold_er[2]}, 32'd0);

        // Reset during the wait of a write aborts it
        txn("wr20", 1'b0, 1'b1, 32'h20, 32'hCAFE_F00D, lat, rd, er, rdy);
        check("wr20_err", {31'd0, er}, 32'd0);
        sel       = 1'b0;
        drv_valid = 1'b1;
        drv_we    = 1'b1;
        drv_addr  = 32'h20;
        drv_wdata = 32'h1234_5678;
        @(posedge clk);
        @(negedge clk);
        drv_valid = 1'b0;
        check("abort_in_wait", {31'd0, obs_ready}, 32'd0);
        reset = 1'b1;
        #1;
        check("abort_ready",     {31'd0, obs_ready},     32'd1);
        check("abort_rsp_valid", {31'd0, obs_rsp_valid}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        seen  = 0;
        repeat (6) begin
            @(posedge clk);
            @(negedge clk);
            if (obs_rsp_valid) seen++;
        end
        check("abort_no_rsp", seen, 32'd0);
        txn("rd20", 1'b0, 1'b0, 32'h20, 32'd0, lat, rd, er, rdy);
        check("rd20_rdata", rd,  32'hCAFE_F00D);
        check("rd20_lat",   lat, 32'd3);

        // Zero wait states
        txn("b_wr8", 1'b1, 1'b1, 32'h8, 32'h55AA_55AA, lat, rd, er, rdy);
        check("b_wr8_lat",      lat,         32'd1);
        check("b_wr8_err",      {31'd0, er}, 32'd0);
        check("b_wr8_ready_lo", rdy,         32'd0);
        txn("b_rd8", 1'b1, 1'b0, 32'h8, 32'd0, lat, rd, er, rdy);
        check("b_rd8_lat",   lat, 32'd1);
        check("b_rd8_rdata", rd,  32'h55AA_55AA);
        txn("b_rd2", 1'b1, 1'b0, 32'h2, 32'd0, lat, rd, er, rdy);
        check("b_rd2_err",   {31'd0, er}, 32'd1);
        check("b_rd2_rdata", rd,          32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
